// File: rtl/audio_tdm_tx.sv
// Stereo/TDM audio serializer: derives BCK and LRCK from the reference clock and
// shifts one buffered multi-channel frame out MSB-first in I2S or left-justified format.
module audio_tdm_tx #(
  parameter int REF_CLK     = 18432000,
  parameter int SAMPLE_RATE = 48000,
  parameter int DATA_WIDTH  = 16,
  parameter int SLOT_WIDTH  = 16,
  parameter int CHANNEL_NUM = 2,
  parameter int BCK_HALF    = REF_CLK / (SAMPLE_RATE * SLOT_WIDTH * CHANNEL_NUM * 2)
) (
  input  logic                              iCLK,
  input  logic                              iRST_N,
  input  logic                              iEnable,
  input  logic                              iMode,
  input  logic                              iMute,
  input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] iSample,
  input  logic                              iValid,
  output logic                              oReady,
  output logic                              oAUD_BCK,
  output logic                              oAUD_LRCK,
  output logic                              oAUD_DATA,
  output logic                              oUnderrun,
  output logic [15:0]                       oUnderrun_Cnt
);

  localparam int FW     = CHANNEL_NUM * SLOT_WIDTH;
  localparam int SW     = CHANNEL_NUM * DATA_WIDTH;
  localparam int DIV_W  = $clog2(BCK_HALF + 1);
  localparam int BIT_W  = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam int SLOT_W = $clog2(CHANNEL_NUM);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCK_HALF - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SLOT_WIDTH - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNEL_NUM - 1);

  logic [DIV_W-1:0]  r_div;
  logic              r_bck;
  logic              r_run;
  logic [BIT_W-1:0]  r_bit;
  logic [SLOT_W-1:0] r_slot;
  logic              r_lrck;
  logic              r_mode;
  logic [FW-1:0]     r_shift;
  logic              r_dly;
  logic [SW-1:0]     r_hold;
  logic [SW-1:0]     r_last;
  logic              r_full;
  logic              r_underrun;
  logic [15:0]       r_ur_cnt;

  logic              w_strobe;
  logic              w_start;
  logic              w_bit_wrap;
  logic              w_slot_wrap;
  logic              w_boundary;
  logic              w_xfer;
  logic [SW-1:0]     w_src;
  logic [FW-1:0]     w_frame;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic              w_lrck_nxt;

  // The shift strobe is the BCK falling toggle; every serial output moves only on it.
  assign w_strobe    = iEnable && r_bck && (r_div == DIV_LAST);
  assign w_start     = iEnable && !r_run;
  assign w_bit_wrap  = (r_bit == BIT_LAST);
  assign w_slot_wrap = (r_slot == SLOT_LAST);
  assign w_boundary  = w_start || (w_strobe && w_bit_wrap && w_slot_wrap);
  assign w_xfer      = iValid && !r_full;
  assign w_src       = r_full ? r_hold : r_last;

  // Each channel is left-aligned in its slot; slot padding stays zero.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_frame = '0;
    if (!iMute) begin
      for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
        w_frame[FW-1-ch*SLOT_WIDTH -: DATA_WIDTH] = w_src[SW-1-ch*DATA_WIDTH -: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_bit_nxt  = r_bit;
    w_slot_nxt = r_slot;
    if (w_start) begin
      w_bit_nxt  = '0;
      w_slot_nxt = '0;
    end else if (w_strobe) begin
      if (w_bit_wrap) begin
        w_bit_nxt  = '0;
        w_slot_nxt = w_slot_wrap ? '0 : r_slot + SLOT_W'(1);
      end else begin
        w_bit_nxt = r_bit + BIT_W'(1);
      end
    end
    if (CHANNEL_NUM == 2) w_lrck_nxt = (w_slot_nxt == SLOT_W'(1));
    else                  w_lrck_nxt = (w_slot_nxt == '0) && (w_bit_nxt == '0);
  end

  // NOTE: the frame-wide holding and shift registers are reset too, so a reset
  // mid-frame can never leak stale samples onto the pins.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_div      <= '0;
      r_bck      <= 1'b0;
      r_run      <= 1'b0;
      r_bit      <= '0;
      r_slot     <= '0;
      r_lrck     <= 1'b0;
      r_mode     <= 1'b0;
      r_shift    <= '0;
      r_dly      <= 1'b0;
      r_hold     <= '0;
      r_last     <= '0;
      r_full     <= 1'b0;
      r_underrun <= 1'b0;
      r_ur_cnt   <= '0;
    end else begin
      // Handshake stays live while the serial side is idle.
      if (w_xfer) begin
        r_hold <= iSample;
        r_full <= 1'b1;
      end else if (w_boundary && r_full) begin
        r_full <= 1'b0;
      end
      r_underrun <= w_boundary && !r_full;
      if (w_boundary && !r_full && (r_ur_cnt != 16'hFFFF)) r_ur_cnt <= r_ur_cnt + 16'd1;

      if (!iEnable) begin
        r_div   <= '0;
        r_bck   <= 1'b0;
        r_run   <= 1'b0;
        r_bit   <= '0;
        r_slot  <= '0;
        r_lrck  <= 1'b0;
        r_shift <= '0;
        r_dly   <= 1'b0;
      end else begin
        r_run <= 1'b1;
        if (r_div == DIV_LAST) begin
          r_div <= '0;
          r_bck <= !r_bck;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
        r_bit  <= w_bit_nxt;
        r_slot <= w_slot_nxt;
        r_lrck <= w_lrck_nxt;
        if (w_boundary) begin
          r_shift <= w_frame;
          r_mode  <= iMode;
          if (r_full) r_last <= r_hold;
        end else if (w_strobe) begin
          r_shift <= r_shift << 1;
        end
        // One-BCK delayed copy of the stream feeds I2S mode.
        if (w_strobe) r_dly <= r_shift[FW-1];
      end
    end
  end

  assign oReady        = !r_full;
  assign oAUD_BCK      = r_bck;
  assign oAUD_LRCK     = r_lrck;
  assign oAUD_DATA     = r_mode ? r_shift[FW-1] : r_dly;
  assign oUnderrun     = r_underrun;
  assign oUnderrun_Cnt = r_ur_cnt;

endmodule

// File: tb/tb_audio_tdm_tx.sv
// Bench for audio_tdm_tx: stereo default instance plus a 4-channel TDM instance,
// expected serial bits queued per frame and compared on each BCK rising edge.
module tb_audio_tdm_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, mode_a, mute_a, valid_a;
  logic [31:0] sample_a;
  logic        a_rdy, a_bck, a_lrck, a_data, a_ur;
  logic [15:0] a_cnt;
  logic        en_b, valid_b;
  logic [95:0] sample_b;
  logic        b_rdy, b_bck, b_lrck, b_data, b_ur;
  logic [15:0] b_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int ur_a = 0, ur_b = 0, xfer_a = 0;
  logic prev_rdy_a = 1'b1;
  logic last_bit_a = 1'b0;
  logic [1:0] q_a[$];
  logic [1:0] q_b[$];

  always #5 clk = ~clk;

  audio_tdm_tx u_stereo (
    .iCLK(clk), .iRST_N(rst_n), .iEnable(en_a), .iMode(mode_a), .iMute(mute_a),
    .iSample(sample_a), .iValid(valid_a), .oReady(a_rdy), .oAUD_BCK(a_bck),
    .oAUD_LRCK(a_lrck), .oAUD_DATA(a_data), .oUnderrun(a_ur), .oUnderrun_Cnt(a_cnt)
  );

  audio_tdm_tx #(
    .REF_CLK(12288000), .SAMPLE_RATE(48000), .DATA_WIDTH(24), .SLOT_WIDTH(32), .CHANNEL_NUM(4)
  ) u_tdm (
    .iCLK(clk), .iRST_N(rst_n), .iEnable(en_b), .iMode(1'b1), .iMute(1'b0),
    .iSample(sample_b), .iValid(valid_b), .oReady(b_rdy), .oAUD_BCK(b_bck),
    .oAUD_LRCK(b_lrck), .oAUD_DATA(b_data), .oUnderrun(b_ur), .oUnderrun_Cnt(b_cnt)
  );

  task automatic tick();
    @(negedge clk);
    if (a_ur) ur_a++;
    if (b_ur) ur_b++;
    if (prev_rdy_a && !a_rdy) xfer_a++;
    prev_rdy_a = a_rdy;
  endtask

  task automatic wait_rise(input bit sel, output int cyc);
    logic prev, cur;
    prev = sel ? b_bck : a_bck;
    cyc  = 0;
    forever begin
      tick();
      cyc++;
      cur = sel ? b_bck : a_bck;
      if (!prev && cur) return;
      prev = cur;
      if (cyc > 1000) begin
        n_vec++; n_miss++;
        $display("FAIL bck_timeout: no BCK rise on dut %0d within %0d cycles", sel, cyc);
        return;
      end
    end
  endtask

  task automatic check_bits(input bit sel, input int n, output int cyc);
    logic [1:0] exp, got;
    for (int k = 0; k < n; k++) begin
      wait_rise(sel, cyc);
      got = sel ? {b_lrck, b_data} : {a_lrck, a_data};
      n_vec++;
      if ((sel ? q_b.size() : q_a.size()) == 0) begin
        n_miss++;
        $display("FAIL scoreboard_empty: dut %0d got lrck/data %b, required nothing queued", sel, got);
      end else begin
        exp = sel ? q_b.pop_front() : q_a.pop_front();
        if (got !== exp) begin
          n_miss++;
          $display("FAIL serial_bit dut %0d t=%0t: lrck/data %b, required %b", sel, $time, got, exp);
        end
      end
    end
  endtask

  task automatic push_frame_a(input logic [15:0] l, input logic [15:0] r, input bit lj, input bit mute);
    logic [31:0] w;
    logic d;
    w = mute ? 32'h0 : {l, r};
    for (int i = 0; i < 32; i++) begin
      d = lj ? w[31-i] : ((i == 0) ? last_bit_a : w[32-i]);
      q_a.push_back({(i >= 16) ? 1'b1 : 1'b0, d});
    end
    last_bit_a = w[0];
  endtask

  task automatic push_frame_b(input logic [95:0] w);
    int c, b;
    for (int i = 0; i < 128; i++) begin
      c = i / 32;
      b = i % 32;
      q_b.push_back({(i == 0) ? 1'b1 : 1'b0, (b < 24) ? w[95 - c*24 - b] : 1'b0});
    end
  endtask

  task automatic expect_val(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic send_a(input logic [31:0] s);
    expect_val("ready_before_send", {15'd0, a_rdy}, 16'd1);
    sample_a = s;
    valid_a  = 1'b1;
    tick();
    valid_a  = 1'b0;
    expect_val("ready_after_send", {15'd0, a_rdy}, 16'd0);
  endtask

  task automatic test_reset();
    #3;
    expect_val("rst_bck",  {15'd0, a_bck},  16'd0);
    expect_val("rst_lrck", {15'd0, a_lrck}, 16'd0);
    expect_val("rst_data", {15'd0, a_data}, 16'd0);
    expect_val("rst_ready", {15'd0, a_rdy}, 16'd1);
    expect_val("rst_underrun", {15'd0, a_ur}, 16'd0);
    expect_val("rst_cnt", a_cnt, 16'd0);
    expect_val("rst_tdm_ready", {15'd0, b_rdy}, 16'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_left_justified();
    int cyc;
    send_a({16'hA5F0, 16'h0F5A});
    mode_a = 1'b1;
    en_a   = 1'b1;
    push_frame_a(16'hA5F0, 16'h0F5A, 1'b1, 1'b0);
    check_bits(0, 1, cyc);
    check_bits(0, 1, cyc);
    expect_val("bck_period", 16'(cyc), 16'd12);
    check_bits(0, 14, cyc);
    send_a({16'hA5F0, 16'h0F5A});
    check_bits(0, 16, cyc);
    expect_val("lj_no_underrun", 16'(ur_a), 16'd0);
    mode_a = 1'b0;
  endtask

  task automatic test_i2s();
    int cyc;
    push_frame_a(16'hA5F0, 16'h0F5A, 1'b0, 1'b0);
    check_bits(0, 32, cyc);
    expect_val("i2s_no_underrun", a_cnt, 16'd0);
  endtask

  task automatic test_underrun_mute();
    int cyc;
    for (int k = 1; k <= 3; k++) begin
      push_frame_a(16'hA5F0, 16'h0F5A, 1'b0, 1'b0);
      check_bits(0, 32, cyc);
      expect_val("underrun_cnt", a_cnt, 16'(k));
      expect_val("underrun_pulses", 16'(ur_a), 16'(k));
    end
    mute_a = 1'b1;
    push_frame_a(16'hA5F0, 16'h0F5A, 1'b0, 1'b1);
    check_bits(0, 32, cyc);
    expect_val("mute_underrun_cnt", a_cnt, 16'd4);
  endtask

  task automatic ready_after_boundary();
    repeat (5) tick();
    expect_val("ready_before_boundary", {15'd0, a_rdy}, 16'd0);
    tick();
    expect_val("ready_rise", {15'd0, a_rdy}, 16'd1);
    tick();
    expect_val("ready_refill", {15'd0, a_rdy}, 16'd0);
  endtask

  task automatic test_back_to_back();
    int cyc, x0;
    x0 = xfer_a;
    repeat (5) tick();
    mute_a   = 1'b0;
    sample_a = {16'h1234, 16'hFEDC};
    valid_a  = 1'b1;
    tick();
    expect_val("boundary_xfer_underrun", a_cnt, 16'd5);
    expect_val("boundary_xfer_ready", {15'd0, a_rdy}, 16'd0);
    mode_a = 1'b1;
    push_frame_a(16'hA5F0, 16'h0F5A, 1'b0, 1'b0);
    check_bits(0, 32, cyc);
    ready_after_boundary();
    push_frame_a(16'h1234, 16'hFEDC, 1'b1, 1'b0);
    check_bits(0, 32, cyc);
    ready_after_boundary();
    valid_a = 1'b0;
    push_frame_a(16'h1234, 16'hFEDC, 1'b1, 1'b0);
    check_bits(0, 32, cyc);
    expect_val("b2b_transfers", 16'(xfer_a - x0), 16'd3);
    expect_val("b2b_cnt", a_cnt, 16'd5);
    expect_val("b2b_pulses", 16'(ur_a), 16'd5);
  endtask

  task automatic test_reset_mid();
    int cyc, c;
    repeat (7) tick();
    send_a({16'h5555, 16'hAAAA});
    for (int k = 0; k < 24; k++) wait_rise(0, cyc);
    expect_val("pre_reset_lrck", {15'd0, a_lrck}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    expect_val("mid_rst_bck",  {15'd0, a_bck},  16'd0);
    expect_val("mid_rst_lrck", {15'd0, a_lrck}, 16'd0);
    expect_val("mid_rst_data", {15'd0, a_data}, 16'd0);
    expect_val("mid_rst_ready", {15'd0, a_rdy}, 16'd1);
    expect_val("mid_rst_cnt", a_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_rdy_a = a_rdy;
    c = 0;
    do begin
      tick();
      c++;
    end while (!a_bck && c < 20);
    expect_val("first_bck_after_reset", 16'(c), 16'd6);
    expect_val("restart_underrun", a_cnt, 16'd1);
  endtask

  task automatic test_disable();
    int cyc;
    for (int k = 0; k < 19; k++) wait_rise(0, cyc);
    expect_val("pre_disable_lrck", {15'd0, a_lrck}, 16'd1);
    en_a = 1'b0;
    tick();
    expect_val("dis_bck",  {15'd0, a_bck},  16'd0);
    expect_val("dis_lrck", {15'd0, a_lrck}, 16'd0);
  endtask

  task automatic test_tdm();
    int cyc;
    logic [95:0] w;
    w = {24'hABCDEF, 24'h123456, 24'h800001, 24'h7FFFFE};
    n_vec++;
    if (b_rdy !== 1'b1) begin
      n_miss++;
      $display("FAIL tdm_ready: got %b, required 1", b_rdy);
    end
    sample_b = w;
    valid_b  = 1'b1;
    tick();
    valid_b  = 1'b0;
    en_b     = 1'b1;
    push_frame_b(w);
    push_frame_b(w);
    check_bits(1, 256, cyc);
    expect_val("tdm_bck_period", 16'(cyc), 16'd2);
    expect_val("tdm_underrun_cnt", b_cnt, 16'd1);
    expect_val("tdm_underrun_pulses", 16'(ur_b), 16'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; mode_a = 1'b1; mute_a = 1'b0; valid_a = 1'b0; sample_a = '0;
    en_b = 1'b0; valid_b = 1'b0; sample_b = '0;
    test_reset();
    test_left_justified();
    test_i2s();
    test_underrun_mute();
    test_back_to_back();
    test_reset_mid();
    test_disable();
    test_tdm();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
